// File: rtl/bus_rd_burst_master.sv
// bus_rd_burst_master: bus read burst master with an FWFT read-data FIFO.
// Ports: iClk/iRst, iCmd* command in, oMstRd*/iMstRd* bus read channel, oRdData* stream out, oBusy/oDone status.
module bus_rd_burst_master #(
  parameter int AW         = 12,
  parameter int DW         = 32,
  parameter int SW         = 4,
  parameter int LW         = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int REQ_SYNC   = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iCmdValid,
  input  logic [AW-1:0] iCmdAddr,
  input  logic [SW-1:0] iCmdSel,
  input  logic [LW-1:0] iCmdLen,
  input  logic          iCmdMode,
  input  logic [7:0]    iCmdGap,
  output logic          oCmdReady,
  output logic          oMstRdReq,
  output logic          oMstRdValid,
  output logic          oMstRdLast,
  output logic [AW-1:0] oMstRdAddr,
  output logic [SW-1:0] oMstRdSel,
  input  logic          iMstRdReady,
  input  logic [DW-1:0] iMstRdData,
  output logic [DW-1:0] oRdData,
  output logic          oRdDataValid,
  output logic          oRdDataLast,
  input  logic          iRdDataReady,
  output logic          oBusy,
  output logic          oDone
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_WAIT, S_BEAT, S_GAP, S_CAPT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [SW-1:0] sel_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beat_q;
  logic          mode_q;
  logic [7:0]    gap_q;
  logic [7:0]    cnt_q;
  logic          cap_pend_q;
  logic          cap_last_q;

  logic          accept;
  logic          hs;
  logic          last_beat;
  logic          space;
  logic [CW:0]   reserve;
  logic          sync_done;

  logic [DW:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic          push, pop;

  assign accept    = (state_q == S_IDLE) & iCmdValid;
  assign hs        = (state_q == S_BEAT) & iMstRdReady;
  assign last_beat = (beat_q == len_q - LW'(1));
  assign sync_done = (cnt_q == 8'(REQ_SYNC - 1));

  // Occupancy counts the word still to be captured and the one
  // handshaking now, so a beat is only issued with a slot reserved.
  assign reserve = {1'b0, fifo_cnt}
                 + (CW+1)'(cap_pend_q)
                 + (CW+1)'(hs);
  assign space   = reserve < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // WAIT is only resident while the FIFO has no reserved slot; with
  // space, SYNC/GAP/BEAT step straight to the next beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (iCmdValid)
                state_d = (iCmdLen == '0) ? S_DONE : S_SYNC;
      S_SYNC: if (sync_done)
                state_d = space ? S_BEAT : S_WAIT;
      S_WAIT: if (space) state_d = S_BEAT;
      S_BEAT: if (iMstRdReady) begin
                if (last_beat)        state_d = S_CAPT;
                else if (gap_q != 0)  state_d = S_GAP;
                else if (space)       state_d = S_BEAT;
                else                  state_d = S_WAIT;
              end
      S_GAP:  if (cnt_q == 8'd0)
                state_d = space ? S_BEAT : S_WAIT;
      S_CAPT: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oCmdReady   = 1'b0;
    oBusy       = 1'b1;
    oDone       = 1'b0;
    oMstRdReq   = 1'b0;
    oMstRdValid = 1'b0;
    oMstRdLast  = 1'b0;
    oMstRdAddr  = '1;
    oMstRdSel   = '0;
    unique case (state_q)
      S_IDLE: begin
        oCmdReady = 1'b1;
        oBusy     = 1'b0;
      end
      S_SYNC, S_WAIT, S_GAP: begin
        oMstRdReq  = 1'b1;
        oMstRdAddr = addr_q;
        oMstRdSel  = sel_q;
      end
      S_BEAT: begin
        oMstRdReq   = 1'b1;
        oMstRdValid = 1'b1;
        oMstRdLast  = last_beat;
        oMstRdAddr  = addr_q;
        oMstRdSel   = sel_q;
      end
      S_DONE: oDone = 1'b1;
      default: ;
    endcase
  end

  // cnt_q counts SYNC cycles up and GAP cycles down.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      addr_q     <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      gap_q      <= '0;
      cnt_q      <= '0;
      cap_pend_q <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      cap_pend_q <= hs;
      cap_last_q <= hs & last_beat;
      if (accept) begin
        addr_q <= iCmdAddr;
        sel_q  <= iCmdSel;
        len_q  <= iCmdLen;
        mode_q <= iCmdMode;
        gap_q  <= iCmdGap;
        beat_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == S_SYNC) begin
        cnt_q <= cnt_q + 8'd1;
      end else if (hs) begin
        beat_q <= beat_q + LW'(1);
        cnt_q  <= gap_q - 8'd1;
        if (!mode_q) addr_q <= addr_q + AW'(DW / 8);
      end else if (state_q == S_GAP) begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  // Read-data FIFO; the slave answers one cycle after the handshake.
  assign push         = cap_pend_q;
  assign oRdDataValid = (fifo_cnt != '0);
  assign pop          = oRdDataValid & iRdDataReady;
  assign oRdData      = mem[rd_ptr][DW-1:0];
  assign oRdDataLast  = mem[rd_ptr][DW];

  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= {cap_last_q, iMstRdData};
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: doc/bus_rd_burst_master.md
BUS_RD_BURST_MASTER -- requirements
Module: bus_rd_burst_master

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line below.
REQ-002 AW, 12, bus address width.
REQ-003 DW, 32, bus data width; multiple of 8.
REQ-004 SW, 4, slave-select width.
REQ-005 LW, 8, burst-length field width.
REQ-006 FIFO_DEPTH, 8, read-data FIFO entries; power of 2, >=2.
REQ-007 REQ_SYNC, 2, cycles between oMstRdReq rise and first oMstRdValid.
REQ-008 SHALL have ports (name direction width meaning), one per line below; one clock; reset is asynchronous and active-high.
REQ-009 iClk in 1 clock, all logic on rising edge.
REQ-010 iRst in 1 asynchronous active-high reset.
REQ-011 iCmdValid in 1 command offered; iCmdAddr in AW start byte address; iCmdSel in SW slave select; iCmdLen in LW beat count; iCmdMode in 1 0=INCR, 1=FIXED; iCmdGap in 8 idle cycles between beats.
REQ-012 oCmdReady out 1 command accepted when high with iCmdValid.
REQ-013 oMstRdReq, oMstRdValid, oMstRdLast out 1; oMstRdAddr out AW; oMstRdSel out SW; iMstRdReady in 1; iMstRdData in DW; bus read channel.
REQ-014 oRdData out DW; oRdDataValid out 1; oRdDataLast out 1; iRdDataReady in 1; FIFO read stream.
REQ-015 oBusy out 1 burst in progress; oDone out 1 one-cycle pulse at burst completion.

Function
REQ-016 SHALL be a synthesizable FSM: IDLE, SYNC, WAIT, BEAT, GAP, CAPT, DONE.
REQ-017 IDLE: oCmdReady=1; on iCmdValid latch all command fields; Len=0 -> DONE directly, no bus activity; else -> SYNC.
REQ-018 SYNC: oMstRdReq=1, oMstRdAddr/oMstRdSel driven, counts exactly REQ_SYNC cycles -> WAIT.
REQ-019 WAIT: Req=1, Valid=0; -> BEAT when FIFO free entries minus pending capture >= 1.
REQ-020 BEAT: Valid=1; Addr, Sel, Last held stable until handshake (Valid & iMstRdReady at rising edge).
REQ-021 oMstRdLast SHALL be 1 only on the final beat (beat index Len-1).
REQ-022 Beat address: INCR = start + n*(DW/8), modulo 2^AW (wraps silently); FIXED = start for every beat.
REQ-023 Data SHALL be sampled from iMstRdData on the cycle after each handshake (registered-slave latency 1) and pushed into FIFO with last flag.
REQ-024 After non-final handshake: Gap>0 -> GAP for exactly Gap cycles (Valid=0, Req=1) -> WAIT; Gap=0 -> WAIT (back-to-back beats allowed if FIFO space).
REQ-025 After final handshake -> CAPT (final capture) -> DONE (oDone=1 one cycle, Req drops) -> IDLE.
REQ-026 oBusy=1 in every state except IDLE; oCmdReady=0 outside IDLE; commands not accepted mid-burst.
REQ-027 Outside SYNC/WAIT/BEAT/GAP: Req=0, Valid=0, Last=0, Addr all-ones, Sel zero.
REQ-028 FIFO: first-word-fall-through; oRdDataValid=!empty; pop on oRdDataValid & iRdDataReady; simultaneous push and pop when full-minus-one or empty SHALL be lossless.
REQ-029 FIFO SHALL never overflow; iRdDataReady low indefinitely stalls bus at WAIT with no beat lost.
REQ-030 iMstRdReady while Valid=0 SHALL be ignored.

Reset
REQ-031 iRst high SHALL asynchronously force IDLE, FIFO empty, oCmdReady=1 (after release), all other outputs per REQ-027, oRdDataValid=0, oDone=0, oBusy=0.
REQ-032 Reset mid-burst SHALL abort the burst, discard FIFO contents, emit no oDone.

Verification
REQ-033 INCR Len=4 Addr=0x100 Gap=0, Ready always 1 -> addresses 0x100,0x104,0x108,0x10C; Last on 4th; first Valid 2 cycles after Req; 4 FIFO words, last flag on 4th; one oDone.
REQ-034 FIXED Len=3 Addr=0x040 Gap=2, Ready delayed 3 cycles per beat -> Addr 0x040 every beat, 2 Valid-low cycles between beats, Addr/Sel stable while waiting.
REQ-035 INCR Len=3 Addr=0xFFC (AW=12) -> addresses 0xFFC,0x000,0x004.
REQ-036 Len=10, FIFO_DEPTH=8, iRdDataReady=0 -> exactly 8 beats, then WAIT with Valid=0; raising iRdDataReady completes remaining 2; 10 words in order.
REQ-037 Len=0 -> oDone one cycle after acceptance, Req never asserted.
REQ-038 iRst pulsed during 3rd beat of Len=6 -> all outputs at reset values immediately, no oDone, next command runs normally.
